// File: rtl/imem_boot_loader_pkg.sv
// imem_pkg: shared types and defaults for the instruction-memory boot loader.
//   state_t            controller states (CHECK/ERROR only reachable with LOAD_CHECKSUM_EN)
//   NUM_WORDS_DEFAULT  default instruction memory depth in words
//   NOP_INSTR_DEFAULT  instruction handed to fetch while stalled (addi x0,x0,0)
package imem_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_WRITE = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam int          NUM_WORDS_DEFAULT = 1024;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream handshake from the loader source.
//   ld_valid  source has a byte
//   ld_data   the byte
//   ld_last   final program byte (only meaningful with ld_valid)
//   ld_ready  controller takes the byte this cycle
// master = loader source (UART receiver / bench), slave = boot loader.
interface imem_boot_loader_if;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;

  modport master (output ld_valid, output ld_data, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_data, input ld_last, output ld_ready);
endinterface

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: assembles little-endian 32-bit words from accepted bytes.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        drop the partial word and restart at lane 0 (wins over accept)
//   accept       a byte is taken this cycle
//   byte_in      the byte
//   last_in      the byte closes the word early (upper lanes remain zero)
//   word         registered assembly
//   word_next    assembly with the current byte merged into its lane
//   word_ready   strobe: this accepted byte completes a word
//   last_seen    a last-flagged byte went into the current word
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  input  logic        last_in,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        word_ready,
  output logic        last_seen
);

  logic [1:0] byte_idx;

  always_comb begin
    word_next = word;
    case (byte_idx)
      2'd0:    word_next[7:0]   = byte_in;
      2'd1:    word_next[15:8]  = byte_in;
      2'd2:    word_next[23:16] = byte_in;
      default: word_next[31:24] = byte_in;
    endcase
  end

  assign word_ready = accept && ((byte_idx == 2'd3) || last_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx  <= 2'd0;
      word      <= 32'd0;
      last_seen <= 1'b0;
    end else if (clear) begin
      byte_idx  <= 2'd0;
      word      <= 32'd0;
      last_seen <= 1'b0;
    end else if (accept) begin
      word     <= word_next;
      byte_idx <= byte_idx + 2'd1;
      if (last_in) last_seen <= 1'b1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: owns the write side of the instruction memory at boot and
// gates instruction fetch until the program is in place.
//   clk, rst_n     clock, asynchronous active-low reset
//   ld             byte stream (slave side of imem_boot_loader_if)
//   reload         one-cycle pulse, restart loading at word 0
//   fetch_pc       fetch byte address; fetch_instr the instruction returned
//   cpu_stall      holds the core while loading
//   mem_addr/mem_wdata/mem_we/mem_rdata  instruction memory port
//   load_done      program loaded, core running
//   words_loaded   number of words written since the last (re)start
//   load_err       checksum mismatch
// Build option: define LOAD_CHECKSUM_EN to require a trailing 4-byte
// little-endian checksum (32-bit modular sum of the written words); without
// it load_err is constant 0.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int          NUM_WORDS = NUM_WORDS_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  imem_boot_loader_if.slave            ld,
  input  logic                         reload,
  input  logic [31:0]                  fetch_pc,
  output logic [31:0]                  fetch_instr,
  output logic                         cpu_stall,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic                         mem_we,
  input  logic [31:0]                  mem_rdata,
  output logic                         load_done,
  output logic [$clog2(NUM_WORDS):0]   words_loaded,
  output logic                         load_err
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_W = $clog2(NUM_WORDS) + 1;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   word_idx;
  logic               byte_slot;
  logic               accept;
  logic               pk_clear;
  logic               pk_last_in;
  logic [31:0]        pk_word;
  logic [31:0]        pk_word_next;
  logic               pk_word_ready;
  logic               pk_last_seen;
  logic               at_cap;
  logic               pc_out_of_range;

  // Byte slots exist only in LOAD (program data) and CHECK (checksum bytes).
`ifdef LOAD_CHECKSUM_EN
  assign byte_slot = (state == ST_LOAD) || (state == ST_CHECK);
`else
  assign byte_slot = (state == ST_LOAD);
`endif

  assign ld.ld_ready = byte_slot;
  // A reload in the same cycle as a handshake drops the byte.
  assign accept      = ld.ld_valid && byte_slot && !reload;
  // The checksum is always four bytes, so last only shortens program words.
  assign pk_last_in  = ld.ld_last && (state == ST_LOAD);
  // Every WRITE consumes the assembled word, whichever state follows.
  assign pk_clear    = reload || (state == ST_WRITE);
  assign at_cap      = (word_idx == IDX_W'(NUM_WORDS - 1));
  assign pc_out_of_range = ({2'b00, fetch_pc[31:2]} >= 32'(NUM_WORDS));

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .accept     (accept),
    .byte_in    (ld.ld_data),
    .last_in    (pk_last_in),
    .word       (pk_word),
    .word_next  (pk_word_next),
    .word_ready (pk_word_ready),
    .last_seen  (pk_last_seen)
  );

`ifdef LOAD_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  csum <= 32'd0;
    else if (reload)             csum <= 32'd0;
    else if (state == ST_WRITE)  csum <= csum + pk_word;
  end
`else
  logic unused_word_next;
  assign unused_word_next = ^pk_word_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    cpu_stall   = 1'b1;
    load_done   = 1'b0;
    load_err    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'(word_idx) << 2;
    mem_wdata   = pk_word;
    fetch_instr = NOP_INSTR;

    case (state)
      ST_LOAD: begin
        if (pk_word_ready) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        if (pk_last_seen || at_cap) begin
`ifdef LOAD_CHECKSUM_EN
          state_nx = ST_CHECK;
`else
          state_nx = ST_RUN;
`endif
        end else begin
          state_nx = ST_LOAD;
        end
      end
      ST_RUN: begin
        cpu_stall   = 1'b0;
        load_done   = 1'b1;
        mem_addr    = fetch_pc;
        fetch_instr = pc_out_of_range ? NOP_INSTR : mem_rdata;
      end
`ifdef LOAD_CHECKSUM_EN
      ST_CHECK: begin
        if (pk_word_ready) state_nx = (pk_word_next == csum) ? ST_RUN : ST_ERROR;
      end
      ST_ERROR: begin
        load_err = 1'b1;
      end
`endif
      default: state_nx = ST_LOAD;
    endcase

    if (reload) state_nx = ST_LOAD;
  end

  // Word pointer stays on the final word when loading ends so the memory
  // write address never runs past the program.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx     <= '0;
      words_loaded <= '0;
    end else if (reload) begin
      word_idx     <= '0;
      words_loaded <= '0;
    end else if (state == ST_WRITE) begin
      words_loaded <= words_loaded + CNT_W'(1);
      if (!(pk_last_seen || at_cap)) word_idx <= word_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a 4-word memory model.
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int NW = 4;
  localparam int CW = $clog2(NW) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reload = 1'b0;
  logic [31:0]   fetch_pc = 32'd0;
  logic [31:0]   fetch_instr;
  logic          cpu_stall;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic          load_done;
  logic [CW-1:0] words_loaded;
  logic          load_err;

  imem_boot_loader_if ld_if ();

  always #5 clk = ~clk;

  imem_boot_loader #(.NUM_WORDS(NW), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld           (ld_if),
    .reload       (reload),
    .fetch_pc     (fetch_pc),
    .fetch_instr  (fetch_instr),
    .cpu_stall    (cpu_stall),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .load_done    (load_done),
    .words_loaded (words_loaded),
    .load_err     (load_err)
  );

  // Memory model: unwritten locations read back as DEADBEEF.
  logic [31:0] mem [0:7];
  bit   [7:0]  mem_vld;
  assign mem_rdata = mem_vld[mem_addr[4:2]] ? mem[mem_addr[4:2]] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[4:2]]     <= mem_wdata;
      mem_vld[mem_addr[4:2]] <= 1'b1;
    end
  end

  // Write log.
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_n = 0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_wdata;
      end
      wr_n++;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one byte at negedge, hold until ld_ready, handshake on posedge.
  // Idle bus carries ld_last=1 with ld_valid=0, which must be ignored.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = b;
    ld_if.ld_last  = last;
    while (ld_if.ld_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 40), 32'd1);
    @(posedge clk);
    #1;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b1;
    ld_if.ld_data  = 8'hFF;
  endtask

  // Called right after the final data byte: checks the WRITE cycle, sends the
  // checksum when built with it, and checks the core is released.
  task automatic finish_load(input string tag, input logic [31:0] sum);
    @(negedge clk);
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_stall_wr"}, 32'(cpu_stall), 32'd1);
`ifdef LOAD_CHECKSUM_EN
    for (int i = 0; i < 4; i++) send_byte(sum[8*i +: 8], i == 3);
`else
    $display("info %s program sum %h", tag, sum);
    @(negedge clk);
`endif
    chk({tag, "_done"}, 32'(load_done), 32'd1);
    chk({tag, "_stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, "_ready"}, 32'(ld_if.ld_ready), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  logic [7:0]  prog1 [0:7];
  logic [7:0]  prog2 [0:5];
  logic [31:0] cap_w [0:3];
  logic [31:0] sum;
  int          base;

  initial begin
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = 8'h00;
    ld_if.ld_last  = 1'b0;
    prog1 = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    prog2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
    cap_w = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fetch_pc = 32'h4;
    #1;
    chk("rst_ready", 32'(ld_if.ld_ready), 32'd1);
    chk("rst_stall", 32'(cpu_stall), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_fetch_nop", fetch_instr, NOP);

    // Two full words, last on byte 8
    base = wr_n;
    for (int i = 0; i < 8; i++) send_byte(prog1[i], i == 7);
    finish_load("p1", 32'h0010_0513 + 32'h0020_0593);
    chk("p1_nwr", 32'(wr_n - base), 32'd2);
    chk("p1_a0", wr_addr[base], 32'h0);
    chk("p1_d0", wr_data[base], 32'h0010_0513);
    chk("p1_a1", wr_addr[base+1], 32'h4);
    chk("p1_d1", wr_data[base+1], 32'h0020_0593);
    chk("p1_words", 32'(words_loaded), 32'd2);

    // Zero-latency fetch and out-of-range NOP
    fetch_pc = 32'h4;         #1; chk("fetch_4", fetch_instr, 32'h0020_0593);
    fetch_pc = 32'h0;         #1; chk("fetch_0", fetch_instr, 32'h0010_0513);
    fetch_pc = 32'h10;        #1; chk("fetch_10", fetch_instr, NOP);
    fetch_pc = 32'hFFFF_FFFC; #1; chk("fetch_top", fetch_instr, NOP);
    fetch_pc = 32'h0;

    // Reload from RUN
    pulse_reload();
    #1;
    chk("rl_stall", 32'(cpu_stall), 32'd1);
    chk("rl_words", 32'(words_loaded), 32'd0);
    chk("rl_done", 32'(load_done), 32'd0);
    chk("rl_ready", 32'(ld_if.ld_ready), 32'd1);

    // Short final word is zero-padded
    base = wr_n;
    for (int i = 0; i < 6; i++) send_byte(prog2[i], i == 5);
    finish_load("p2", 32'h0403_0201 + 32'h0000_BBAA);
    chk("p2_nwr", 32'(wr_n - base), 32'd2);
    chk("p2_d0", wr_data[base], 32'h0403_0201);
    chk("p2_a1", wr_addr[base+1], 32'h4);
    chk("p2_d1", wr_data[base+1], 32'h0000_BBAA);
    chk("p2_words", 32'(words_loaded), 32'd2);

    // Capacity without ld_last
    pulse_reload();
    base = wr_n;
    sum = 32'd0;
    for (int i = 0; i < 4; i++) sum = sum + cap_w[i];
    for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 1'b0);
    finish_load("cap", sum);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_last  = 1'b0;
    ld_if.ld_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cap_backpressure", 32'(ld_if.ld_ready), 32'd0);
    end
    ld_if.ld_valid = 1'b0;
    @(negedge clk);
    chk("cap_nwr", 32'(wr_n - base), 32'd4);
    chk("cap_a3", wr_addr[base+3], 32'hC);
    chk("cap_d3", wr_data[base+3], cap_w[3]);
    chk("cap_d1", wr_data[base+1], cap_w[1]);
    chk("cap_words", 32'(words_loaded), 32'd4);
    fetch_pc = 32'h8; #1; chk("cap_fetch_8", fetch_instr, cap_w[2]);
    fetch_pc = 32'h0;

    // Reload, then asynchronous reset after two bytes of a new word
    pulse_reload();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(cpu_stall), 32'd1);
    chk("arst_words", 32'(words_loaded), 32'd0);
    chk("arst_ready", 32'(ld_if.ld_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    base = wr_n;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    finish_load("arst", 32'h0033_2211);
    chk("arst_nwr", 32'(wr_n - base), 32'd1);
    chk("arst_a0", wr_addr[base], 32'h0);
    chk("arst_d0", wr_data[base], 32'h0033_2211);
    chk("arst_words_after", 32'(words_loaded), 32'd1);

`ifdef LOAD_CHECKSUM_EN
    // Bad checksum holds the core in ERROR
    pulse_reload();
    for (int i = 0; i < 4; i++) send_byte(prog1[i], i == 3);
    @(negedge clk);
    send_byte(8'h14, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b1);
    repeat (3) @(negedge clk);
    chk("cs_bad_err", 32'(load_err), 32'd1);
    chk("cs_bad_stall", 32'(cpu_stall), 32'd1);
    chk("cs_bad_ready", 32'(ld_if.ld_ready), 32'd0);
    chk("cs_bad_done", 32'(load_done), 32'd0);
    // Matching checksum releases the core
    pulse_reload();
    #1;
    chk("cs_rl_err", 32'(load_err), 32'd0);
    for (int i = 0; i < 4; i++) send_byte(prog1[i], i == 3);
    finish_load("cs_good", 32'h0010_0513);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
